// File: rtl/credit_arbiter_pkg.sv
// Shared types for the credit arbiter: FSM state encoding and default
// pointer sizing.
package credit_arbiter_pkg;

    localparam int unsigned CA_NUM_REQ = 4;
    localparam int unsigned CA_PTR_W   = $clog2(CA_NUM_REQ);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ca_state_e;

endpackage

// File: rtl/delta_counter.sv
// Up/down counter that moves by an arbitrary delta per cycle.
// Priority: clear, then load, then enabled step. overflow_o flags a
// wrap in either direction, either per-event or sticky until clear.
module delta_counter #(
    parameter int unsigned WIDTH           = 8,
    parameter bit          STICKY_OVERFLOW = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] delta_i,
    output logic [WIDTH-1:0] q_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] q_q;
    logic             ovf_q;
    logic [WIDTH:0]   step;
    logic             ovf_evt;

    // One extra bit captures carry (up) or borrow (down).
    always_comb begin
        step = down_i ? ({1'b0, q_q} - {1'b0, delta_i})
                      : ({1'b0, q_q} + {1'b0, delta_i});
        ovf_evt = en_i && step[WIDTH];
    end

    // Counter value and overflow flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else if (clear_i) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else if (load_i) begin
            q_q   <= d_i;
            ovf_q <= STICKY_OVERFLOW ? ovf_q : 1'b0;
        end else begin
            if (en_i) q_q <= step[WIDTH-1:0];
            ovf_q <= STICKY_OVERFLOW ? (ovf_q | ovf_evt) : ovf_evt;
        end
    end

    assign q_o        = q_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/credit_arbiter.sv
// Round-robin credit arbiter with a shared credit pool, release path,
// sticky underflow flag and a flush/drain handshake.
// Optional: define CREDIT_ARBITER_STATS_EN to add grant_cnt_o, a count
// of non-zero-delta grants cleared on drain completion.
module credit_arbiter
    import credit_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = CA_NUM_REQ,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_CREDITS = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_delta_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     rel_valid_i,
    input  logic [WIDTH-1:0]         rel_delta_i,
    input  logic                     flush_i,
    output logic                     flush_done_o,
    output logic [WIDTH-1:0]         used_o,
`ifdef CREDIT_ARBITER_STATS_EN
    output logic [31:0]              grant_cnt_o,
`endif
    output logic                     error_o
);

    localparam int unsigned    PTR_W  = (NUM_REQ == CA_NUM_REQ) ? CA_PTR_W : $clog2(NUM_REQ);
    localparam logic [WIDTH:0] MAX_W1 = (WIDTH+1)'(MAX_CREDITS);

    ca_state_e                     state_q, state_d;
    logic [PTR_W-1:0]              ptr_q;
    logic                          error_q;
    logic [NUM_REQ-1:0][WIDTH-1:0] delta;

    logic                          sel_found;
    logic [PTR_W-1:0]              sel_idx;
    logic [PTR_W-1:0]              cand;
    logic [WIDTH-1:0]              sel_delta;
    logic [WIDTH:0]                sel_sum;
    logic                          grant;

    logic [WIDTH:0]                grant_amt;
    logic [WIDTH:0]                rel_amt;
    logic [WIDTH:0]                avail;
    logic                          underflow;
    logic                          net_down;
    logic [WIDTH-1:0]              net_mag;
    logic                          unused_cnt_ovf;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign delta[i] = req_delta_i[i*WIDTH +: WIDTH];
    end

    // Round-robin search from ptr; first valid requester is selected.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % int'(NUM_REQ));
            if (!sel_found && req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Selected requester is granted only if its delta fits; no bypass.
    always_comb begin
        sel_delta   = delta[sel_idx];
        sel_sum     = {1'b0, used_o} + {1'b0, sel_delta};
        grant       = rst_ni && (state_q == RUN) && sel_found &&
                      ((sel_delta == '0) || (sel_sum <= MAX_W1));
        req_ready_o = '0;
        if (grant) req_ready_o[sel_idx] = 1'b1;
    end

    // Net credit change as sign/magnitude; underflow reloads zero.
    always_comb begin
        grant_amt = grant ? {1'b0, sel_delta} : '0;
        rel_amt   = rel_valid_i ? {1'b0, rel_delta_i} : '0;
        avail     = {1'b0, used_o} + grant_amt;
        underflow = rel_amt > avail;
        net_down  = rel_amt > grant_amt;
        net_mag   = net_down ? (rel_amt[WIDTH-1:0] - grant_amt[WIDTH-1:0])
                             : (grant_amt[WIDTH-1:0] - rel_amt[WIDTH-1:0]);
    end

    delta_counter #(
        .WIDTH          (WIDTH),
        .STICKY_OVERFLOW(1'b0)
    ) u_used_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (1'b0),
        .load_i    (underflow),
        .d_i       ('0),
        .en_i      (net_mag != '0),
        .down_i    (net_down),
        .delta_i   (net_mag),
        .q_o       (used_o),
        .overflow_o(unused_cnt_ovf)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RUN;
        else         state_q <= state_d;
    end

    // Next-state and flush-done decode; DONE lasts exactly one cycle.
    always_comb begin
        state_d      = state_q;
        flush_done_o = 1'b0;
        case (state_q)
            RUN:     if (flush_i) state_d = DRAIN;
            DRAIN:   if (used_o == '0) state_d = DONE;
            DONE: begin
                flush_done_o = 1'b1;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Pointer advances past the winner; holds when nothing is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (grant) begin
            ptr_q <= (int'(sel_idx) == int'(NUM_REQ) - 1) ? '0 : sel_idx + 1'b1;
        end
    end

    // Sticky release-underflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        error_q <= 1'b0;
        else if (underflow) error_q <= 1'b1;
    end

    assign error_o = error_q;

`ifdef CREDIT_ARBITER_STATS_EN
    logic [31:0] grant_cnt_q;

    // Non-zero-delta grant counter, cleared on drain completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                        grant_cnt_q <= '0;
        else if (state_q == DONE)           grant_cnt_q <= '0;
        else if (grant && sel_delta != '0)  grant_cnt_q <= grant_cnt_q + 32'd1;
    end

    assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_credit_arbiter.sv
// Bench for credit_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the pool.
module tb_credit_arbiter;

    localparam int NR  = 4;
    localparam int W   = 8;
    localparam int MAX = 16;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [NR-1:0]   req_valid_i;
    logic [NR*W-1:0] req_delta_i;
    logic [NR-1:0]   req_ready_o;
    logic            rel_valid_i;
    logic [W-1:0]    rel_delta_i;
    logic            flush_i;
    logic            flush_done_o;
    logic [W-1:0]    used_o;
    logic            error_o;
`ifdef CREDIT_ARBITER_STATS_EN
    logic [31:0]     grant_cnt_o;
`endif

    credit_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_CREDITS(MAX)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_delta_i (req_delta_i),
        .req_ready_o (req_ready_o),
        .rel_valid_i (rel_valid_i),
        .rel_delta_i (rel_delta_i),
        .flush_i     (flush_i),
        .flush_done_o(flush_done_o),
        .used_o      (used_o),
`ifdef CREDIT_ARBITER_STATS_EN
        .grant_cnt_o (grant_cnt_o),
`endif
        .error_o     (error_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Requester-side view: pending request and its delta.
    bit v [NR];
    int d [NR];

    // Model: credits held, next search start, mode (0 run, 1 drain, 2 done).
    int m_used, m_ptr, m_st, m_gcnt;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid_i[i]         = v[i];
            req_delta_i[i*W +: W]  = W'(d[i]);
        end
    endtask

    task automatic rel(input int x);
        rel_valid_i = 1'b1;
        rel_delta_i = W'(x);
    endtask

    // One clock: check outputs against the model, then advance the model.
    // want >= 0 pins the granted index, want == -1 pins no grant.
    task automatic cycle(input int want = -2, input int want_fd = -1);
        int g, gd, rr, u0, e;
        drive();
        #3;
        g = -1;
        if (m_st == 0) begin
            for (int i = 0; i < NR; i++) begin
                int k = (m_ptr + i) % NR;
                if (v[k]) begin
                    if (d[k] == 0 || m_used + d[k] <= MAX) g = k;
                    break;
                end
            end
        end
        e = (g >= 0) ? (1 << g) : 0;
        chk("ready", 32'(req_ready_o), e);
        if (want != -2) chk("ready_spec", 32'(req_ready_o), (want < 0) ? 0 : (1 << want));
        chk("used", 32'(used_o), m_used);
        chk("error", 32'(error_o), 32'(m_err));
        chk("fdone", 32'(flush_done_o), (m_st == 2) ? 1 : 0);
        if (want_fd >= 0) chk("fdone_spec", 32'(flush_done_o), want_fd);
`ifdef CREDIT_ARBITER_STATS_EN
        chk("gcnt", grant_cnt_o, 32'(m_gcnt));
`endif
        u0 = m_used;
        gd = (g >= 0) ? d[g] : 0;
        rr = rel_valid_i ? int'(rel_delta_i) : 0;
        if (rr > m_used + gd) begin
            m_used = 0;
            m_err  = 1'b1;
        end else begin
            m_used = m_used + gd - rr;
        end
        if (g >= 0) begin
            m_ptr = (g + 1) % NR;
            if (gd != 0) m_gcnt++;
            v[g] = 1'b0;
        end
        case (m_st)
            0:       if (flush_i) m_st = 1;
            1:       if (u0 == 0) m_st = 2;
            default: begin m_st = 0; m_gcnt = 0; end
        endcase
        @(posedge clk);
        #1;
        rel_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic do_reset(input bit keep);
        if (!keep) for (int i = 0; i < NR; i++) v[i] = 1'b0;
        drive();
        rel_valid_i = 1'b0;
        flush_i     = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_used", 32'(used_o), 0);
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_error", 32'(error_o), 0);
        chk("rst_fdone", 32'(flush_done_o), 0);
`ifdef CREDIT_ARBITER_STATS_EN
        chk("rst_gcnt", grant_cnt_o, 0);
`endif
        m_used = 0; m_ptr = 0; m_st = 0; m_err = 1'b0; m_gcnt = 0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic all_req(input int dv);
        for (int i = 0; i < NR; i++) begin v[i] = 1'b1; d[i] = dv; end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin v[i] = 1'b0; d[i] = 0; end
        rel_valid_i = 1'b0; rel_delta_i = '0; flush_i = 1'b0;
        drive();
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Fairness: rotating grants until the pool is full.
        for (int c = 0; c < 16; c++) begin
            all_req(1);
            cycle(c % 4);
        end
        chk("fair_used", 32'(used_o), 16);
        all_req(1);
        cycle(-1);

        // Credit blocking at the pointer, no bypass to requester 3.
        do_reset(1'b0);
        v[0] = 1; d[0] = 14; cycle(0);
        v[1] = 1; d[1] = 0;  cycle(1);
        chk("blk_used14", 32'(used_o), 14);
        v[2] = 1; d[2] = 3; v[3] = 1; d[3] = 1;
        cycle(-1);
        rel(1); cycle(-1);
        cycle(2);
        chk("blk_used16", 32'(used_o), 16);

        // Grant and release in the same cycle.
        do_reset(1'b0);
        v[0] = 1; d[0] = 10; cycle(0);
        v[1] = 1; d[1] = 4; rel(6); cycle(1);
        chk("net_used", 32'(used_o), 8);

        // Release underflow sets the sticky error.
        do_reset(1'b0);
        v[0] = 1; d[0] = 2; cycle(0);
        rel(5); cycle(-1);
        chk("uf_used", 32'(used_o), 0);
        chk("uf_err", 32'(error_o), 1);
        v[1] = 1; d[1] = 3; cycle(1);
        v[2] = 1; d[2] = 2; rel(1); cycle(2);
        chk("uf_sticky", 32'(error_o), 1);

        // Flush with a concurrent grant, then drain by releases.
        do_reset(1'b0);
        v[0] = 1; d[0] = 4; cycle(0);
        v[1] = 1; d[1] = 1; flush_i = 1; cycle(1);
        chk("fl_used5", 32'(used_o), 5);
        v[2] = 1; d[2] = 1;
        rel(2); cycle(-1, 0);
        rel(3); cycle(-1, 0);
        chk("fl_used0", 32'(used_o), 0);
        cycle(-1, 0);
        cycle(-1, 1);
        cycle(2, 0);

        // Asynchronous reset in the middle of a drain.
        do_reset(1'b0);
        v[0] = 1; d[0] = 7; cycle(0);
        flush_i = 1; cycle(-1);
        v[1] = 1; d[1] = 2; cycle(-1, 0);
        chk("rd_used7", 32'(used_o), 7);
        do_reset(1'b1);
        cycle(1, 0);
        cycle(-1, 0);
        cycle(-1, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v[i] && $urandom_range(0, 99) < 40) begin
                    v[i] = 1'b1;
                    d[i] = int'($urandom_range(0, 8));
                end
            end
            if ($urandom_range(0, 99) < 35) begin
                if ($urandom_range(0, 99) < 5) rel(m_used + 1 + int'($urandom_range(0, 2)));
                else                            rel(int'($urandom_range(0, m_used)));
            end
            if ($urandom_range(0, 99) < 3) flush_i = 1'b1;
            if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
            else                             cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
